// File: rtl/cpu_stack_if.sv
`default_nettype none
// ============================================================================
// Module   : cpu_stack_if
// Brief    : Request/response and byte-serial memory port bundle of the
//            stack sequencer.
// Revision : 1.0
// ============================================================================
interface cpu_stack_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int SP_WIDTH   = 8
);
    logic                  req_valid;
    logic                  req_ready;
    logic [1:0]            req_op;
    logic [ADDR_WIDTH-1:0] req_data;
    logic                  resp_valid;
    logic                  resp_fault;
    logic [ADDR_WIDTH-1:0] resp_data;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_data_out;
    logic [DATA_WIDTH-1:0] mem_data_in;
    logic                  mem_write_en;
    logic                  mem_read_en;
    logic [SP_WIDTH-1:0]   sp_out;
    logic [SP_WIDTH:0]     count_out;
    logic                  empty;
    logic                  full;

    // Engine side.
    modport slave (
        input  req_valid, req_op, req_data, mem_data_in,
        output req_ready, resp_valid, resp_fault, resp_data,
               mem_addr, mem_data_out, mem_write_en, mem_read_en,
               sp_out, count_out, empty, full
    );

    // Control unit and memory side.
    modport master (
        output req_valid, req_op, req_data, mem_data_in,
        input  req_ready, resp_valid, resp_fault, resp_data,
               mem_addr, mem_data_out, mem_write_en, mem_read_en,
               sp_out, count_out, empty, full
    );
endinterface
`default_nettype wire

// File: rtl/cpu_stack_engine.sv
`default_nettype none
// ============================================================================
// Module   : cpu_stack_engine
// Brief    : Multi-cycle byte/word push-pop stack sequencer with occupancy
//            tracking and overflow/underflow fault reporting.
// Revision : 1.0
// ============================================================================
module cpu_stack_engine #(
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    DATA_WIDTH = 8,
    parameter int                    SP_WIDTH   = 8,
    parameter int                    SP_INIT    = 255,
    parameter logic [ADDR_WIDTH-1:0] STACK_BASE = '0
) (
    input  wire logic   clk,
    input  wire logic   rst,
    cpu_stack_if.slave  bus
);

    localparam int c_WB       = ADDR_WIDTH / DATA_WIDTH;
    localparam int c_KW       = (c_WB > 1) ? $clog2(c_WB) : 1;
    localparam int c_CW       = SP_WIDTH + 1;
    localparam int c_CAP_INT  = SP_INIT + 1;
    localparam int c_LAST_INT = c_WB - 1;

    localparam logic [SP_WIDTH-1:0] c_SPI     = SP_INIT[SP_WIDTH-1:0];
    localparam logic [c_CW-1:0]     c_CAP     = c_CAP_INT[c_CW-1:0];
    localparam logic [c_CW:0]       c_CAP_X   = c_CAP_INT[c_CW:0];
    localparam logic [c_CW:0]       c_WB_X    = c_WB[c_CW:0];
    localparam logic [c_CW:0]       c_ONE_X   = 1;
    localparam logic [c_KW-1:0]     c_LAST_K  = c_LAST_INT[c_KW-1:0];

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PUSH  = 3'd1,
        ST_POP   = 3'd2,
        ST_RESP  = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [1:0]             op_q, op_d;
    logic [ADDR_WIDTH-1:0]  data_q, data_d;
    logic [c_KW-1:0]        k_q, k_d;
    logic [c_CW-1:0]        count_q, count_d;

    logic [SP_WIDTH-1:0]    w_sp;
    logic [SP_WIDTH-1:0]    w_slot;
    logic [c_KW-1:0]        w_k_last;
    logic                   w_last;
    logic [c_CW:0]          w_req_n;
    logic [c_CW:0]          w_count_x;
    logic                   w_strobe;

    // sp is derived from occupancy so the two can never disagree.
    assign w_sp      = c_SPI - count_q[SP_WIDTH-1:0];
    assign w_slot    = (state_q == ST_POP) ? (w_sp + SP_WIDTH'(1)) : w_sp;
    assign w_k_last  = op_q[1] ? c_LAST_K : '0;
    assign w_last    = (k_q == w_k_last);
    assign w_req_n   = bus.req_op[1] ? c_WB_X : c_ONE_X;
    assign w_count_x = {1'b0, count_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            data_q  <= '0;
            k_q     <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            data_q  <= data_d;
            k_q     <= k_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        data_d  = data_q;
        k_d     = k_q;
        count_d = count_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    op_d = bus.req_op;
                    k_d  = '0;
                    if (bus.req_op[0]) begin
                        data_d  = '0;
                        state_d = (w_count_x < w_req_n) ? ST_FAULT : ST_POP;
                    end else begin
                        // Push data is left-aligned so the next byte out is always the top byte.
                        data_d  = bus.req_op[1] ? bus.req_data
                                                : (bus.req_data << (ADDR_WIDTH - DATA_WIDTH));
                        state_d = ((w_count_x + w_req_n) > c_CAP_X) ? ST_FAULT : ST_PUSH;
                    end
                end
            end
            ST_PUSH: begin
                data_d  = data_q << DATA_WIDTH;
                count_d = count_q + c_CW'(1);
                k_d     = k_q + c_KW'(1);
                if (w_last) begin
                    state_d = ST_RESP;
                end
            end
            ST_POP: begin
                for (int b = 0; b < c_WB; b++) begin
                    if (k_q == c_KW'(b)) begin
                        data_d[b*DATA_WIDTH +: DATA_WIDTH] = bus.mem_data_in;
                    end
                end
                count_d = count_q - c_CW'(1);
                k_d     = k_q + c_KW'(1);
                if (w_last) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            ST_FAULT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign w_strobe         = (state_q == ST_PUSH) || (state_q == ST_POP);

    assign bus.req_ready    = (state_q == ST_IDLE);
    assign bus.resp_valid   = (state_q == ST_RESP) || (state_q == ST_FAULT);
    assign bus.resp_fault   = (state_q == ST_FAULT);
    assign bus.resp_data    = ((state_q == ST_RESP) && op_q[0]) ? data_q : '0;

    assign bus.mem_write_en = (state_q == ST_PUSH);
    assign bus.mem_read_en  = (state_q == ST_POP);
    assign bus.mem_addr     = w_strobe ? (STACK_BASE + ADDR_WIDTH'(w_slot)) : '0;
    assign bus.mem_data_out = (state_q == ST_PUSH) ? data_q[ADDR_WIDTH-1 -: DATA_WIDTH] : '0;

    assign bus.sp_out       = w_sp;
    assign bus.count_out    = count_q;
    assign bus.empty        = (count_q == '0);
    assign bus.full         = (count_q == c_CAP);

endmodule
`default_nettype wire

// File: tb/tb_cpu_stack_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_stack_engine
// Brief    : Directed self-checking bench for the stack sequencer (16-bit
//            default instance and a 24-bit, based instance).
// Revision : 1.0
// ============================================================================
module tb_cpu_stack_engine;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cpu_stack_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .SP_WIDTH(8)) b16 ();
    cpu_stack_if #(.ADDR_WIDTH(24), .DATA_WIDTH(8), .SP_WIDTH(8)) b24 ();

    cpu_stack_engine #(
        .ADDR_WIDTH(16), .DATA_WIDTH(8), .SP_WIDTH(8),
        .SP_INIT(255), .STACK_BASE(16'h0000)
    ) u_dut16 (
        .clk (clk),
        .rst (rst),
        .bus (b16)
    );

    cpu_stack_engine #(
        .ADDR_WIDTH(24), .DATA_WIDTH(8), .SP_WIDTH(8),
        .SP_INIT(255), .STACK_BASE(24'h000100)
    ) u_dut24 (
        .clk (clk),
        .rst (rst),
        .bus (b24)
    );

    logic [7:0] mem16 [0:1023];
    logic [7:0] mem24 [0:1023];

    always @(posedge clk) begin
        if (b16.mem_write_en) mem16[b16.mem_addr[9:0]] <= b16.mem_data_out;
        if (b24.mem_write_en) mem24[b24.mem_addr[9:0]] <= b24.mem_data_out;
    end
    assign b16.mem_data_in = mem16[b16.mem_addr[9:0]];
    assign b24.mem_data_in = mem24[b24.mem_addr[9:0]];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one request on the 16-bit instance from an idle negedge; returns after the response cycle.
    task automatic do_req16(input logic [1:0] op, input logic [15:0] data, input string tag,
                            output logic fault, output logic [15:0] rdata);
        logic got;
        got   = 1'b0;
        fault = 1'b0;
        rdata = '0;
        b16.req_valid = 1'b1;
        b16.req_op    = op;
        b16.req_data  = data;
        @(negedge clk);
        b16.req_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (b16.resp_valid) begin
                got   = 1'b1;
                fault = b16.resp_fault;
                rdata = b16.resp_data;
                break;
            end
            @(negedge clk);
        end
        chk({tag, "_resp"}, {31'd0, got}, 32'd1);
        if (got) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        f;
        logic [15:0] r;
        int          wcnt;
        int          rcnt;
        logic        seen;

        rst = 1'b1;
        b16.req_valid = 1'b0; b16.req_op = 2'b00; b16.req_data = '0;
        b24.req_valid = 1'b0; b24.req_op = 2'b00; b24.req_data = '0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_sp",    b16.sp_out,       32'hFF);
        chk("rst_count", b16.count_out,    32'd0);
        chk("rst_empty", b16.empty,        32'd1);
        chk("rst_full",  b16.full,         32'd0);
        chk("rst_ready", b16.req_ready,    32'd1);
        chk("rst_we",    b16.mem_write_en, 32'd0);
        chk("rst_re",    b16.mem_read_en,  32'd0);
        chk("rst_rv",    b16.resp_valid,   32'd0);
        chk("rst_addr",  b16.mem_addr,     32'd0);
        chk("rst_dout",  b16.mem_data_out, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // push_word 0x1234: MSB first, descending addresses
        b16.req_valid = 1'b1; b16.req_op = 2'b10; b16.req_data = 16'h1234;
        @(negedge clk);
        b16.req_valid = 1'b0;
        chk("pw_c1_we",    b16.mem_write_en, 32'd1);
        chk("pw_c1_re",    b16.mem_read_en,  32'd0);
        chk("pw_c1_addr",  b16.mem_addr,     32'h00FF);
        chk("pw_c1_dout",  b16.mem_data_out, 32'h12);
        chk("pw_c1_ready", b16.req_ready,    32'd0);
        @(negedge clk);
        chk("pw_c2_we",    b16.mem_write_en, 32'd1);
        chk("pw_c2_addr",  b16.mem_addr,     32'h00FE);
        chk("pw_c2_dout",  b16.mem_data_out, 32'h34);
        @(negedge clk);
        chk("pw_c3_rv",    b16.resp_valid,   32'd1);
        chk("pw_c3_fault", b16.resp_fault,   32'd0);
        chk("pw_c3_we",    b16.mem_write_en, 32'd0);
        chk("pw_c3_rdata", b16.resp_data,    32'd0);
        @(negedge clk);
        chk("pw_sp",       b16.sp_out,       32'hFD);
        chk("pw_count",    b16.count_out,    32'd2);
        chk("pw_rv_off",   b16.resp_valid,   32'd0);

        // pop_word: LSB from lower address first
        b16.req_valid = 1'b1; b16.req_op = 2'b11; b16.req_data = 16'hFFFF;
        @(negedge clk);
        b16.req_valid = 1'b0;
        chk("pop_c1_re",   b16.mem_read_en,  32'd1);
        chk("pop_c1_we",   b16.mem_write_en, 32'd0);
        chk("pop_c1_addr", b16.mem_addr,     32'h00FE);
        chk("pop_c1_dout", b16.mem_data_out, 32'd0);
        @(negedge clk);
        chk("pop_c2_re",   b16.mem_read_en,  32'd1);
        chk("pop_c2_addr", b16.mem_addr,     32'h00FF);
        @(negedge clk);
        chk("pop_c3_rv",   b16.resp_valid,   32'd1);
        chk("pop_c3_flt",  b16.resp_fault,   32'd0);
        chk("pop_c3_data", b16.resp_data,    32'h1234);
        @(negedge clk);
        chk("pop_sp",      b16.sp_out,       32'hFF);
        chk("pop_empty",   b16.empty,        32'd1);

        // pop_byte on empty stack faults in cycle 1
        b16.req_valid = 1'b1; b16.req_op = 2'b01;
        @(negedge clk);
        b16.req_valid = 1'b0;
        chk("uf_rv",    b16.resp_valid,   32'd1);
        chk("uf_fault", b16.resp_fault,   32'd1);
        chk("uf_we",    b16.mem_write_en, 32'd0);
        chk("uf_re",    b16.mem_read_en,  32'd0);
        chk("uf_data",  b16.resp_data,    32'd0);
        @(negedge clk);
        chk("uf_sp",    b16.sp_out,       32'hFF);
        chk("uf_count", b16.count_out,    32'd0);
        chk("uf_ready", b16.req_ready,    32'd1);

        // req_valid held through a busy push_word: one write sequence only
        wcnt = 0; rcnt = 0;
        b16.req_valid = 1'b1; b16.req_op = 2'b10; b16.req_data = 16'hBEEF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (b16.mem_write_en) wcnt++;
            if (b16.resp_valid)   rcnt++;
        end
        chk("busy_ready", b16.req_ready, 32'd0);
        b16.req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (b16.mem_write_en) wcnt++;
            if (b16.resp_valid)   rcnt++;
        end
        chk("busy_writes", wcnt, 32'd2);
        chk("busy_resps",  rcnt, 32'd1);
        chk("busy_count",  b16.count_out, 32'd2);
        chk("busy_sp",     b16.sp_out,    32'hFD);
        do_req16(2'b11, 16'h0000, "busy_pop", f, r);
        chk("busy_pop_flt",  f, 32'd0);
        chk("busy_pop_data", r, 32'hBEEF);

        // Fill to 255 bytes, then overflow checks
        for (int i = 0; i < 255; i++) begin
            logic [7:0] pb;
            pb = 8'(i) ^ 8'h5A;
            do_req16(2'b00, {8'hC3, pb}, "fill", f, r);
        end
        chk("fill_count", b16.count_out, 32'd255);
        chk("fill_sp",    b16.sp_out,    32'h00);
        chk("fill_full",  b16.full,      32'd0);

        b16.req_valid = 1'b1; b16.req_op = 2'b10; b16.req_data = 16'h7777;
        @(negedge clk);
        b16.req_valid = 1'b0;
        chk("of_w_rv",    b16.resp_valid,   32'd1);
        chk("of_w_fault", b16.resp_fault,   32'd1);
        chk("of_w_we",    b16.mem_write_en, 32'd0);
        @(negedge clk);
        chk("of_w_count", b16.count_out,    32'd255);
        chk("of_w_sp",    b16.sp_out,       32'h00);

        do_req16(2'b00, 16'h00A5, "last", f, r);
        chk("last_fault", f,             32'd0);
        chk("full_flag",  b16.full,      32'd1);
        chk("full_sp",    b16.sp_out,    32'hFF);
        chk("full_count", b16.count_out, 32'd256);
        chk("full_empty", b16.empty,     32'd0);

        b16.req_valid = 1'b1; b16.req_op = 2'b00; b16.req_data = 16'h0011;
        @(negedge clk);
        b16.req_valid = 1'b0;
        chk("of_b_fault", b16.resp_fault,   32'd1);
        chk("of_b_rv",    b16.resp_valid,   32'd1);
        chk("of_b_we",    b16.mem_write_en, 32'd0);
        @(negedge clk);

        // pop at full reads slot sp+1, which wraps to slot 0
        b16.req_valid = 1'b1; b16.req_op = 2'b01;
        @(negedge clk);
        b16.req_valid = 1'b0;
        chk("pf_re",   b16.mem_read_en, 32'd1);
        chk("pf_addr", b16.mem_addr,    32'h0000);
        @(negedge clk);
        chk("pf_rv",   b16.resp_valid,  32'd1);
        chk("pf_data", b16.resp_data,   32'h00A5);
        @(negedge clk);
        chk("pf_count", b16.count_out,  32'd255);

        // Reset mid push_word
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        b16.req_valid = 1'b1; b16.req_op = 2'b10; b16.req_data = 16'h5678;
        @(negedge clk);
        b16.req_valid = 1'b0;
        chk("mr_c1_we",  b16.mem_write_en, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mr_c2_we",  b16.mem_write_en, 32'd0);
        chk("mr_c2_rv",  b16.resp_valid,   32'd0);
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (b16.resp_valid || b16.mem_write_en) seen = 1'b1;
        end
        chk("mr_quiet",  seen,          32'd0);
        chk("mr_sp",     b16.sp_out,    32'hFF);
        chk("mr_count",  b16.count_out, 32'd0);

        // 24-bit instance with STACK_BASE 0x0100
        b24.req_valid = 1'b1; b24.req_op = 2'b10; b24.req_data = 24'hABCDEF;
        @(negedge clk);
        b24.req_valid = 1'b0;
        chk("w24_c1_addr", b24.mem_addr,     32'h0001FF);
        chk("w24_c1_dout", b24.mem_data_out, 32'hAB);
        chk("w24_c1_we",   b24.mem_write_en, 32'd1);
        @(negedge clk);
        chk("w24_c2_addr", b24.mem_addr,     32'h0001FE);
        chk("w24_c2_dout", b24.mem_data_out, 32'hCD);
        @(negedge clk);
        chk("w24_c3_addr", b24.mem_addr,     32'h0001FD);
        chk("w24_c3_dout", b24.mem_data_out, 32'hEF);
        @(negedge clk);
        chk("w24_c4_rv",   b24.resp_valid,   32'd1);
        chk("w24_c4_flt",  b24.resp_fault,   32'd0);
        @(negedge clk);
        chk("w24_sp",      b24.sp_out,       32'hFC);
        chk("w24_count",   b24.count_out,    32'd3);

        b24.req_valid = 1'b1; b24.req_op = 2'b11;
        @(negedge clk);
        b24.req_valid = 1'b0;
        chk("r24_c1_addr", b24.mem_addr,     32'h0001FD);
        @(negedge clk);
        chk("r24_c2_addr", b24.mem_addr,     32'h0001FE);
        @(negedge clk);
        chk("r24_c3_addr", b24.mem_addr,     32'h0001FF);
        chk("r24_c3_re",   b24.mem_read_en,  32'd1);
        @(negedge clk);
        chk("r24_c4_rv",   b24.resp_valid,   32'd1);
        chk("r24_c4_data", b24.resp_data,    32'hABCDEF);
        @(negedge clk);
        chk("r24_empty",   b24.empty,        32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
